// File: rtl/codec_unit_pkg.sv
// Shared types and default sizes for the codec interface units.
package codec_unit_pkg;

  localparam int unsigned I2S_DATA_WIDTH_DEF = 24;
  localparam int unsigned I2S_FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    CAPTURE   = 2'd1,
    HOLD      = 2'd2
  } i2s_rx_state_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_chan_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Stereo frame FIFO with registered head data, full and empty flags.
module i2s_rx_fifo
  import codec_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * I2S_DATA_WIDTH_DEF,
  parameter int unsigned DEPTH = I2S_FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i & ~empty_q;
    do_push  = push_i & (~full_q | do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      rd_data_d = push_data_i;
    end else begin
      rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/i2s_rx_unit.sv
// I2S record-path receiver: synchronizes the CODEC pins, frames left/right words, buffers stereo frames.
// Define I2S_RX_FRAME_ERR_CNT_EN to build the saturating short-word error counter.
module i2s_rx_unit
  import codec_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = I2S_FIFO_DEPTH_DEF
) (
  input  logic                    board_clk,
  input  logic                    reset,
  input  logic                    ac_bclk,
  input  logic                    ac_reclrc,
  input  logic                    ac_recdat,
  input  logic                    rx_en,
  output logic [2*DATA_WIDTH-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    overrun,
  input  logic                    overrun_clr,
  output logic                    frame_err,
  output logic [15:0]             frame_err_cnt
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned FW = 2 * DATA_WIDTH;

  logic [1:0]          bclk_s_q, lrc_s_q, dat_s_q;
  logic                bclk_prev_q, bclk_rise_q, lrc_smp_q, dat_smp_q;
  i2s_rx_state_e       state_q, state_d;
  i2s_chan_e           chan_q, chan_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                lrc_prev_q, lrc_prev_d;
  logic                push_q, push_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                lrc_edge_c, drop_c;
  logic                fifo_full, fifo_empty;

  // Pin synchronizers; lrc/data get one extra stage so they line up with bclk_rise.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      bclk_s_q    <= '0;
      lrc_s_q     <= '0;
      dat_s_q     <= '0;
      bclk_prev_q <= 1'b0;
      bclk_rise_q <= 1'b0;
      lrc_smp_q   <= 1'b0;
      dat_smp_q   <= 1'b0;
    end else begin
      bclk_s_q    <= {bclk_s_q[0], ac_bclk};
      lrc_s_q     <= {lrc_s_q[0], ac_reclrc};
      dat_s_q     <= {dat_s_q[0], ac_recdat};
      bclk_prev_q <= bclk_s_q[1];
      bclk_rise_q <= bclk_s_q[1] & ~bclk_prev_q;
      lrc_smp_q   <= lrc_s_q[1];
      dat_smp_q   <= dat_s_q[1];
    end
  end

  assign lrc_edge_c = lrc_smp_q ^ lrc_prev_q;

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    bit_cnt_d   = bit_cnt_q;
    left_d      = left_q;
    right_d     = right_q;
    lrc_prev_d  = lrc_prev_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    if (bclk_rise_q) begin
      lrc_prev_d = lrc_smp_q;
    end
    if (!rx_en) begin
      state_d   = SYNC_WAIT;
      bit_cnt_d = '0;
    end else if (bclk_rise_q) begin
      case (state_q)
        SYNC_WAIT: begin
          if (lrc_edge_c && !lrc_smp_q) begin
            state_d   = CAPTURE;
            chan_d    = CH_LEFT;
            bit_cnt_d = '0;
          end
        end
        CAPTURE: begin
          if (lrc_edge_c) begin
            // Short word: drop the partial frame and resync on the new channel.
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            chan_d      = CH_LEFT;
            state_d     = lrc_smp_q ? SYNC_WAIT : CAPTURE;
          end else begin
            if (chan_q == CH_LEFT) begin
              left_d = {left_q[DATA_WIDTH-2:0], dat_smp_q};
            end else begin
              right_d = {right_q[DATA_WIDTH-2:0], dat_smp_q};
            end
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (lrc_edge_c) begin
            bit_cnt_d = '0;
            state_d   = CAPTURE;
            if (lrc_smp_q) begin
              chan_d = CH_RIGHT;
            end else begin
              chan_d = CH_LEFT;
              push_d = (chan_q == CH_RIGHT);
            end
          end
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  assign drop_c = push_q & fifo_full & ~(rx_valid & rx_ready);

  always_comb begin
    overrun_d = (overrun_q & ~overrun_clr) | drop_c;
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC_WAIT;
      chan_q      <= CH_LEFT;
      bit_cnt_q   <= '0;
      left_q      <= '0;
      right_q     <= '0;
      lrc_prev_q  <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      bit_cnt_q   <= bit_cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      lrc_prev_q  <= lrc_prev_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Shift registers stay stable for several cycles after a push, so they feed the FIFO directly.
  i2s_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (board_clk),
    .rst         (reset),
    .push_i      (push_q),
    .push_data_i ({left_q, right_q}),
    .pop_i       (rx_ready),
    .rd_data_o   (rx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rx_valid  = ~fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

`ifdef I2S_RX_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (frame_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_err_cnt = err_cnt_q;
`else
  assign frame_err_cnt = 16'd0;
`endif

endmodule
